// File: rtl/sms_pkg.sv
// Shared types and constants for the SMS latch bank: channel state encoding,
// mode values and the counter-width helper.
package sms_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    TIMED = 2'd2
  } sms_state_t;

  localparam logic LATCH    = 1'b0;
  localparam logic ONE_SHOT = 1'b1;

  // Counter must hold PULSE_LEN-1; never narrower than one bit.
  function automatic int cnt_width(input int pulse_len);
    int w;
    w = $clog2(pulse_len + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sms_latch_cell.sv
// One SMS latch channel: IDLE/HELD/TIMED state, one-shot hold counter and
// registered rising-edge strobe.
module sms_latch_cell
  import sms_pkg::*;
#(
  parameter int SET_INPUTS = 2,
  parameter int CLR_WINS   = 1,
  parameter int PULSE_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  r,
  input  logic [SET_INPUTS-1:0] set_n,
  input  logic                  clr_n,
  input  logic                  mode,
  output logic                  q,
  output logic                  set_pulse
);

  localparam int            CW       = cnt_width(PULSE_LEN);
  localparam logic [CW-1:0] RELOAD   = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic          CLR_DOM  = (CLR_WINS != 0);

  sms_state_t    state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          pulse_reg;
  logic          set_req, clr_req, set_win, clr_win;

  // Only a solid 0 is a request; floating or unknown pins read as inactive.
  always_comb begin
    set_req = 1'b0;
    for (int k = 0; k < SET_INPUTS; k++) begin
      if (set_n[k] === 1'b0) set_req = 1'b1;
    end
    clr_req = (clr_n === 1'b0);
    set_win = set_req & ~(clr_req & CLR_DOM);
    clr_win = clr_req & ~(set_req & ~CLR_DOM);
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (set_win) begin
          if (mode == ONE_SHOT) begin
            state_next = TIMED;
            cnt_next   = RELOAD;
          end else begin
            state_next = HELD;
          end
        end
      end
      HELD: begin
        if (clr_win) state_next = IDLE;
      end
      TIMED: begin
        if (clr_win) begin
          state_next = IDLE;
          cnt_next   = CNT_ZERO;
        end else if (set_win) begin
          cnt_next = RELOAD;
        end else if (cnt_reg == CNT_ZERO) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_reg <= IDLE;
      cnt_reg   <= CNT_ZERO;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // Strobe only on leaving IDLE, so retriggers and held states never pulse.
      pulse_reg <= (state_reg == IDLE) && (state_next != IDLE);
    end
  end

  assign q         = (state_reg != IDLE);
  assign set_pulse = pulse_reg;

endmodule

// File: rtl/sms_latch_bank.sv
// Bank of independent SMS set/clear latches sharing clock and master reset.
module sms_latch_bank
  import sms_pkg::*;
#(
  parameter int CHANNELS   = 2,
  parameter int SET_INPUTS = 2,
  parameter int CLR_WINS   = 1,
  parameter int PULSE_LEN  = 4
) (
  input  logic                           clk,
  input  logic                           r,
  input  logic [CHANNELS*SET_INPUTS-1:0] set_n,
  input  logic [CHANNELS-1:0]            clr_n,
  input  logic [CHANNELS-1:0]            mode,
  output logic [CHANNELS-1:0]            q,
  output logic [CHANNELS-1:0]            q_n,
  output logic [CHANNELS-1:0]            set_pulse,
  output logic                           any_set
);

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      sms_latch_cell #(
        .SET_INPUTS(SET_INPUTS),
        .CLR_WINS  (CLR_WINS),
        .PULSE_LEN (PULSE_LEN)
      ) u_cell (
        .clk      (clk),
        .r        (r),
        .set_n    (set_n[gi*SET_INPUTS +: SET_INPUTS]),
        .clr_n    (clr_n[gi]),
        .mode     (mode[gi]),
        .q        (q[gi]),
        .set_pulse(set_pulse[gi])
      );
    end
  endgenerate

  assign q_n     = ~q;
  assign any_set = |q;

endmodule

// File: tb/tb_sms_latch_bank.sv
// Directed and randomized checks of sms_latch_bank across three parameter sets.
module tb_sms_latch_bank;

  logic clk = 1'b0;
  logic r   = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // A: defaults (clear wins, PULSE_LEN=4)
  logic [3:0] a_set_n = '1;
  logic [1:0] a_clr_n = '1, a_mode = '0;
  logic [1:0] a_q, a_q_n, a_pulse;
  logic       a_any;
  // B: set dominates
  logic [3:0] b_set_n = '1;
  logic [1:0] b_clr_n = '1, b_mode = '0;
  logic [1:0] b_q, b_q_n, b_pulse;
  logic       b_any;
  // C: 8 channels x 3 set inputs, PULSE_LEN=3
  localparam int CPL = 3;
  logic [23:0] c_set_n = '1;
  logic [7:0]  c_clr_n = '1, c_mode = '0;
  logic [7:0]  c_q, c_q_n, c_pulse;
  logic        c_any;

  sms_latch_bank dut_a (
    .clk(clk), .r(r), .set_n(a_set_n), .clr_n(a_clr_n), .mode(a_mode),
    .q(a_q), .q_n(a_q_n), .set_pulse(a_pulse), .any_set(a_any));

  sms_latch_bank #(.CLR_WINS(0)) dut_b (
    .clk(clk), .r(r), .set_n(b_set_n), .clr_n(b_clr_n), .mode(b_mode),
    .q(b_q), .q_n(b_q_n), .set_pulse(b_pulse), .any_set(b_any));

  sms_latch_bank #(.CHANNELS(8), .SET_INPUTS(3), .CLR_WINS(1), .PULSE_LEN(CPL)) dut_c (
    .clk(clk), .r(r), .set_n(c_set_n), .clr_n(c_clr_n), .mode(c_mode),
    .q(c_q), .q_n(c_q_n), .set_pulse(c_pulse), .any_set(c_any));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_set_n = '0; a_clr_n = '1; a_mode = 2'b10;
    r = 1'b1;
    tick(); tick();
    checks++; if (a_q !== 2'b00) begin failures++; $display("FAIL reset_q got=%b exp=00", a_q); end
    checks++; if (a_q_n !== 2'b11) begin failures++; $display("FAIL reset_q_n got=%b exp=11", a_q_n); end
    checks++; if (a_pulse !== 2'b00) begin failures++; $display("FAIL reset_pulse got=%b exp=00", a_pulse); end
    checks++; if (a_any !== 1'b0) begin failures++; $display("FAIL reset_any got=%b exp=0", a_any); end
    checks++; if (c_q !== 8'h00) begin failures++; $display("FAIL reset_c_q got=%h exp=00", c_q); end
    a_set_n = '1; a_mode = '0;
    r = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_latch();
    a_mode = '0;
    a_set_n[0] = 1'b0; tick();
    checks++; if (a_q !== 2'b01) begin failures++; $display("FAIL latch_set_q got=%b exp=01", a_q); end
    checks++; if (a_q_n !== 2'b10) begin failures++; $display("FAIL latch_set_q_n got=%b exp=10", a_q_n); end
    checks++; if (a_pulse !== 2'b01) begin failures++; $display("FAIL latch_pulse got=%b exp=01", a_pulse); end
    checks++; if (a_any !== 1'b1) begin failures++; $display("FAIL latch_any got=%b exp=1", a_any); end
    a_set_n[0] = 1'b1; tick();
    checks++; if (a_q !== 2'b01) begin failures++; $display("FAIL latch_hold_q got=%b exp=01", a_q); end
    checks++; if (a_pulse !== 2'b00) begin failures++; $display("FAIL latch_pulse_once got=%b exp=00", a_pulse); end
    a_set_n[1] = 1'b0; tick(); a_set_n[1] = 1'b1; tick();
    checks++; if (a_pulse !== 2'b00 || a_q !== 2'b01) begin failures++; $display("FAIL latch_reset_while_held q=%b pulse=%b exp q=01 pulse=00", a_q, a_pulse); end
    a_clr_n[0] = 1'b0; tick(); a_clr_n[0] = 1'b1;
    checks++; if (a_q !== 2'b00) begin failures++; $display("FAIL latch_clr_q got=%b exp=00", a_q); end
    checks++; if (a_q_n !== 2'b11 || a_any !== 1'b0) begin failures++; $display("FAIL latch_clr_qn_any q_n=%b any=%b exp 11/0", a_q_n, a_any); end
    $display("test_latch done");
  endtask

  // Channel 1 one-shot; set held one clock, optional retrigger during the
  // second high clock (lands on the third), mode flipped to LATCH after start.
  task automatic test_one_shot(input int retrig_at, input int exp_hi, input string name);
    int hi, pul;
    a_mode[1] = 1'b1;
    a_set_n[2] = 1'b0; tick();
    a_set_n[2] = 1'b1; a_mode[1] = 1'b0;
    hi = 0; pul = 0;
    for (int c = 0; c < 12; c++) begin
      if (a_q[1] === 1'b1) hi++;
      if (a_pulse[1] === 1'b1) pul++;
      a_set_n[2] = (c == retrig_at) ? 1'b0 : 1'b1;
      tick();
    end
    a_set_n[2] = 1'b1;
    checks++; if (hi != exp_hi) begin failures++; $display("FAIL %s_high_clocks got=%0d exp=%0d", name, hi, exp_hi); end
    checks++; if (pul != 1) begin failures++; $display("FAIL %s_pulse_count got=%0d exp=1", name, pul); end
    checks++; if (a_q !== 2'b00) begin failures++; $display("FAIL %s_end_q got=%b exp=00", name, a_q); end
    $display("test_one_shot %s done high=%0d pulses=%0d", name, hi, pul);
  endtask

  task automatic test_clr_wins();
    a_set_n[0] = 1'b0; a_clr_n[0] = 1'b0;
    b_set_n[0] = 1'b0; b_clr_n[0] = 1'b0;
    tick();
    checks++; if (a_q[0] !== 1'b0) begin failures++; $display("FAIL clrwins1_idle got=%b exp=0", a_q[0]); end
    checks++; if (b_q[0] !== 1'b1) begin failures++; $display("FAIL clrwins0_idle got=%b exp=1", b_q[0]); end
    a_clr_n[0] = 1'b1; tick();
    checks++; if (a_q[0] !== 1'b1) begin failures++; $display("FAIL clrwins1_set got=%b exp=1", a_q[0]); end
    a_clr_n[0] = 1'b0; b_clr_n[0] = 1'b0; tick();
    checks++; if (a_q[0] !== 1'b0) begin failures++; $display("FAIL clrwins1_held got=%b exp=0", a_q[0]); end
    checks++; if (b_q[0] !== 1'b1) begin failures++; $display("FAIL clrwins0_held got=%b exp=1", b_q[0]); end
    a_set_n[0] = 1'b1; b_set_n[0] = 1'b1; tick();
    checks++; if (b_q !== 2'b00 || b_q_n !== 2'b11) begin failures++; $display("FAIL clrwins0_clear q=%b q_n=%b exp 00/11", b_q, b_q_n); end
    a_clr_n = '1; b_clr_n = '1; tick();
    $display("test_clr_wins done");
  endtask

  // Floating pins; a 2-state simulator cannot hold Z, so fall back to 1.
  task automatic test_open_pins();
    logic probe;
    logic fl;
    int bad;
    probe = 1'bz;
    fl = (probe === 1'bz) ? 1'bz : 1'b1;
    r = 1'b1; tick(); r = 1'b0;
    a_set_n = {4{fl}}; a_clr_n = {2{fl}};
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (a_q !== 2'b00) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL open_pins_idle bad_clocks=%0d exp=0", bad); end
    a_clr_n = '1; a_set_n = '1; a_mode = '0;
    a_set_n[0] = 1'b0; tick();
    a_set_n[0] = fl;
    tick(); tick(); tick();
    checks++; if (a_q !== 2'b01) begin failures++; $display("FAIL open_pins_held got=%b exp=01", a_q); end
    a_set_n = '1; a_clr_n[0] = 1'b0; tick(); a_clr_n = '1;
    $display("test_open_pins done floating=%b", fl);
  endtask

  task automatic test_reset_mid();
    a_mode[1] = 1'b1;
    a_set_n[2] = 1'b0; tick();
    a_set_n[2] = 1'b1; tick();
    checks++; if (a_q[1] !== 1'b1) begin failures++; $display("FAIL rstmid_running got=%b exp=1", a_q[1]); end
    r = 1'b1; a_set_n[2] = 1'b0; tick();
    checks++; if (a_q !== 2'b00 || a_pulse !== 2'b00) begin failures++; $display("FAIL rstmid_forced q=%b pulse=%b exp 00/00", a_q, a_pulse); end
    tick();
    checks++; if (a_q !== 2'b00) begin failures++; $display("FAIL rstmid_override got=%b exp=00", a_q); end
    r = 1'b0; tick();
    checks++; if (a_q[1] !== 1'b1 || a_pulse[1] !== 1'b1) begin failures++; $display("FAIL rstmid_release q=%b pulse=%b exp 1/1", a_q[1], a_pulse[1]); end
    a_set_n[2] = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    checks++; if (a_q !== 2'b00) begin failures++; $display("FAIL rstmid_expire got=%b exp=00", a_q); end
    a_mode = '0;
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic [7:0] m_q, m_lat, m_pulse;
    int m_rem [8];
    logic sreq, creq;
    r = 1'b1; tick(); r = 1'b0;
    m_q = '0; m_lat = '0; m_pulse = '0;
    for (int i = 0; i < 8; i++) m_rem[i] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < 8; i++) begin
        for (int k = 0; k < 3; k++) c_set_n[i*3+k] = ($urandom_range(0, 9) != 0);
        c_clr_n[i] = ($urandom_range(0, 11) != 0);
        c_mode[i]  = $urandom_range(0, 1) == 1;
      end
      r = (cyc % 500 == 250);
      for (int i = 0; i < 8; i++) begin
        sreq = ~&c_set_n[i*3 +: 3];
        creq = ~c_clr_n[i];
        m_pulse[i] = 1'b0;
        if (r) begin
          m_q[i] = 1'b0; m_lat[i] = 1'b0; m_rem[i] = 0;
        end else if (!m_q[i]) begin
          if (sreq && !creq) begin
            m_q[i] = 1'b1; m_pulse[i] = 1'b1;
            m_lat[i] = !c_mode[i]; m_rem[i] = CPL;
          end
        end else if (m_lat[i]) begin
          if (creq) m_q[i] = 1'b0;
        end else begin
          if (creq) m_q[i] = 1'b0;
          else if (sreq) m_rem[i] = CPL;
          else if (m_rem[i] == 1) m_q[i] = 1'b0;
          else m_rem[i]--;
        end
      end
      tick();
      checks++; if (c_q !== m_q) begin failures++; $display("FAIL rand_q cyc=%0d got=%h exp=%h", cyc, c_q, m_q); end
      checks++; if (c_pulse !== m_pulse) begin failures++; $display("FAIL rand_pulse cyc=%0d got=%h exp=%h", cyc, c_pulse, m_pulse); end
      checks++; if (c_any !== (|m_q) || c_q_n !== ~m_q) begin failures++; $display("FAIL rand_any cyc=%0d any=%b q_n=%h exp any=%b q_n=%h", cyc, c_any, c_q_n, |m_q, ~m_q); end
    end
    r = 1'b0; c_set_n = '1; c_clr_n = '1;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_latch();
    test_one_shot(-1, 4, "oneshot");
    test_one_shot(1, 6, "retrig");
    test_clr_wins();
    test_open_pins();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sms_latch_bank.md
SMS_LATCH_BANK -- requirements
Module: sms_latch_bank

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent latch channels, range 1..16.
REQ-002 Parameter SET_INPUTS, default 2: active-low set inputs per channel, range 1..4.
REQ-003 Parameter CLR_WINS, default 1: 1 = clear dominates a simultaneous set; 0 = set dominates.
REQ-004 Parameter PULSE_LEN, default 4: one-shot hold length in clocks, range 1..255.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 r  input  1  master reset, synchronous, active-high; shared by all channels.
REQ-007 set_n  input  CHANNELS*SET_INPUTS  active-low set requests; channel i owns bits [i*SET_INPUTS +: SET_INPUTS].
REQ-008 clr_n  input  CHANNELS  active-low per-channel clear.
REQ-009 mode  input  CHANNELS  per-channel mode: 0 = LATCH, 1 = ONE_SHOT.
REQ-010 q  output  CHANNELS  latch state, active-high.
REQ-011 q_n  output  CHANNELS  complement of q.
REQ-012 set_pulse  output  CHANNELS  one-clock strobe on each 0->1 transition of q.
REQ-013 any_set  output  1  OR of all q bits.

Function
REQ-014 Set and clear inputs at X or Z SHALL be treated as logic 1 (inactive), matching open-pin SMS card behaviour.
REQ-015 Channel set request = any of its set_n bits at 0; clear request = clr_n at 0.
REQ-016 Requests SHALL be sampled on the rising clk edge; q updates in that same edge (latency 1 clock from stable input).
REQ-017 Per channel, state machine: IDLE (q=0), HELD (q=1, LATCH mode), TIMED (q=1, ONE_SHOT, counter running).
REQ-018 IDLE + set request, no winning clear -> HELD if mode=0, TIMED with counter=PULSE_LEN-1 if mode=1.
REQ-019 HELD + clear request -> IDLE; HELD with no clear stays HELD regardless of set.
REQ-020 TIMED: counter decrements each clock; at counter=0 with no retrigger -> IDLE, so q is high exactly PULSE_LEN clocks.
REQ-021 TIMED + set request (clear not winning) SHALL reload counter to PULSE_LEN-1 (retrigger).
REQ-022 TIMED + clear request (winning) -> IDLE immediately, counter cleared.
REQ-023 Simultaneous set and clear: CLR_WINS=1 -> IDLE; CLR_WINS=0 -> set path of REQ-018/021 (HELD stays HELD).
REQ-024 mode sampled only on IDLE->set transition; changes while HELD or TIMED are ignored until IDLE.
REQ-025 q_n SHALL always equal ~q; any_set combinational from q.
REQ-026 set_pulse registered: high for the clock after q rises, never on retrigger or while held.
REQ-027 Channels SHALL be fully independent; only clk and r are shared.

Reset
REQ-028 r=1 at a rising edge SHALL force every channel to IDLE: q=0, q_n=all ones, set_pulse=0, counters=0, any_set=0.
REQ-029 r SHALL override all set and clear requests, including mid one-shot.
REQ-030 First edge after r deasserts SHALL evaluate requests normally.

Structure
REQ-031 Shared package sms_pkg SHALL hold the channel state enum (IDLE, HELD, TIMED) and the mode constants LATCH=0, ONE_SHOT=1.
REQ-032 One sub-module sms_latch_cell (single channel: state, counter, pulse) instantiated CHANNELS times via generate.
REQ-033 Counter width SHALL be $clog2(PULSE_LEN+1), minimum 1 bit.

Verification
REQ-034 Defaults, mode=0, pull set_n[0]=0 one clock -> q[0]=1 next edge, set_pulse[0]=1 one clock, q stays 1 after set released; clr_n[0]=0 -> q[0]=0.
REQ-035 mode=1, PULSE_LEN=4, one-clock set on channel 1 -> q[1]=1 exactly 4 clocks; retrigger at clock 3 -> 6 clocks total, set_pulse once.
REQ-036 CLR_WINS=1, set_n and clr_n both 0 on IDLE channel -> q stays 0; CLR_WINS=0 same stimulus -> q=1.
REQ-037 set_n and clr_n driven Z for 10 clocks after reset -> q=0 throughout; set_n bit to 0 then Z on HELD channel -> q stays 1.
REQ-038 r=1 mid one-shot (counter=2) and while set_n held 0 -> q=0 next edge; r released with set still 0 -> q=1 following edge.
REQ-039 CHANNELS=8, SET_INPUTS=3, random per-channel stimulus 2000 clocks vs reference model -> no mismatch in q, set_pulse, any_set.
